// File: rtl/hba_uart_cmd.sv
// Byte-stream command parser: turns 2-byte reads / 3-byte writes into one
// bus-master transfer request and returns read data as a single response byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CMD   | idle, waiting for the command byte {rnw, 3'b000, core}
// S_REG   | waiting for the register-address byte
// S_DATA  | waiting for the write-data byte (writes only)
// S_ISSUE | one-cycle start strobe to the bus master
// S_WAIT  | waiting for the master's completion pulse
// S_TX    | holding the read-response byte until it is taken
module hba_uart_cmd #(
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int RX_TIMEOUT        = 50000
) (
    input  logic                         hba_clk,
    input  logic                         hba_reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [PERIPH_ADDR_WIDTH-1:0] app_core_addr,
    output logic [REG_ADDR_WIDTH-1:0]    app_reg_addr,
    output logic [7:0]                   app_data_in,
    output logic                         app_rnw,
    output logic                         app_en_strobe,
    input  logic [7:0]                   app_data_out,
    input  logic                         app_valid_out,
    output logic                         busy,
    output logic                         cmd_err
);

    localparam int CNT_W = $clog2(RX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RX_TIMEOUT);

    typedef enum logic [2:0] {
        S_CMD, S_REG, S_DATA, S_ISSUE, S_WAIT, S_TX
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;

    assign rx_ready = (state == S_CMD) || (state == S_REG) || (state == S_DATA);
    assign busy     = (state != S_CMD);

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            state         <= S_CMD;
            idle_cnt      <= '0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            app_core_addr <= '0;
            app_reg_addr  <= '0;
            app_data_in   <= '0;
            app_rnw       <= 1'b0;
            app_en_strobe <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            app_en_strobe <= 1'b0;
            cmd_err       <= 1'b0;
            case (state)
                S_CMD: begin
                    if (rx_valid) begin
                        if (rx_data[6:4] != 3'b000) begin
                            cmd_err <= 1'b1;
                        end else begin
                            app_rnw       <= rx_data[7];
                            app_core_addr <= PERIPH_ADDR_WIDTH'(rx_data[3:0]);
                            app_data_in   <= '0;
                            idle_cnt      <= '0;
                            state         <= S_REG;
                        end
                    end
                end
                S_REG, S_DATA: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        if (state == S_REG) begin
                            app_reg_addr <= REG_ADDR_WIDTH'(rx_data);
                            if (app_rnw) begin
                                app_en_strobe <= 1'b1;
                                state         <= S_ISSUE;
                            end else begin
                                state <= S_DATA;
                            end
                        end else begin
                            app_data_in   <= rx_data;
                            app_en_strobe <= 1'b1;
                            state         <= S_ISSUE;
                        end
                    end else if (idle_cnt >= CNT_LAST) begin
                        // partial command abandoned; fields are overwritten by the next one
                        idle_cnt <= '0;
                        cmd_err  <= 1'b1;
                        state    <= S_CMD;
                    end else if (idle_cnt != CNT_MAX) begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (app_valid_out) begin
                        if (app_rnw) begin
                            tx_data  <= app_data_out;
                            tx_valid <= 1'b1;
                            state    <= S_TX;
                        end else begin
                            state <= S_CMD;
                        end
                    end
                end
                S_TX: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_CMD;
                    end
                end
                default: state <= S_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_hba_uart_cmd.sv
// Bench for hba_uart_cmd: directed command table, hand-written reset and
// back-to-back sequences, then random commands against a transaction-level model.
module tb_hba_uart_cmd;

    localparam int TO = 8;

    logic       hba_clk = 1'b0;
    logic       hba_reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] app_core_addr;
    logic [7:0] app_reg_addr;
    logic [7:0] app_data_in;
    logic       app_rnw;
    logic       app_en_strobe;
    logic [7:0] app_data_out;
    logic       app_valid_out;
    logic       busy;
    logic       cmd_err;

    logic       mst_valid = 1'b0;
    logic [7:0] mst_data  = 8'h00;
    logic       man_valid = 1'b0;
    logic       mst_en    = 1'b1;
    int         mst_delay = 2;
    logic [7:0] mst_rdata = 8'h00;

    assign app_valid_out = mst_valid | man_valid;
    assign app_data_out  = mst_data;

    always #5 hba_clk = ~hba_clk;

    hba_uart_cmd #(.PERIPH_ADDR_WIDTH(4), .REG_ADDR_WIDTH(8), .RX_TIMEOUT(TO)) dut (
        .hba_clk(hba_clk), .hba_reset(hba_reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .app_core_addr(app_core_addr), .app_reg_addr(app_reg_addr),
        .app_data_in(app_data_in), .app_rnw(app_rnw), .app_en_strobe(app_en_strobe),
        .app_data_out(app_data_out), .app_valid_out(app_valid_out),
        .busy(busy), .cmd_err(cmd_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observed traffic, sampled on the falling edge.
    int         strobe_cnt = 0;
    int         err_cnt    = 0;
    int         tx_cnt     = 0;
    logic [3:0] last_core  = '0;
    logic [7:0] last_reg   = '0;
    logic [7:0] last_data  = '0;
    logic       last_rnw   = 1'b0;
    logic       prev_strobe = 1'b0;
    logic       prev_tx     = 1'b0;
    logic       pend        = 1'b0;

    always @(negedge hba_clk) begin
        logic inflight;
        if (app_en_strobe) begin
            strobe_cnt++;
            last_core = app_core_addr;
            last_reg  = app_reg_addr;
            last_data = app_data_in;
            last_rnw  = app_rnw;
            chk("strobe_width", prev_strobe, 1'b0);
        end
        if (cmd_err) err_cnt++;
        if (tx_valid && !prev_tx) tx_cnt++;
        inflight = app_en_strobe || (pend && busy);
        if (inflight) chk("rx_ready_in_flight", rx_ready, 1'b0);
        pend        = inflight;
        prev_strobe = app_en_strobe;
        prev_tx     = tx_valid;
    end

    // Bus master: answers each strobe after mst_delay cycles.
    always begin
        @(negedge hba_clk);
        if (app_en_strobe && mst_en) begin
            repeat (mst_delay) @(negedge hba_clk);
            mst_data  = mst_rdata;
            mst_valid = 1'b1;
            @(negedge hba_clk);
            mst_valid = 1'b0;
        end
    end

    typedef struct packed {
        logic [7:0] b0, b1, b2;
        int         nb, gap, tail, stall;
        logic [7:0] rdata;
        logic       e_err, e_strobe, e_rnw;
        logic [3:0] e_core;
        logic [7:0] e_reg, e_data;
        logic       e_tx;
        logic [7:0] e_txd;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, input int nb, gap, tail, stall,
                                input logic [7:0] rdata, input logic e_err, e_strobe, e_rnw,
                                input logic [3:0] e_core, input logic [7:0] e_reg, e_data,
                                input logic e_tx, input logic [7:0] e_txd);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.nb = nb; v.gap = gap; v.tail = tail;
        v.stall = stall; v.rdata = rdata; v.e_err = e_err; v.e_strobe = e_strobe;
        v.e_rnw = e_rnw; v.e_core = e_core; v.e_reg = e_reg; v.e_data = e_data;
        v.e_tx = e_tx; v.e_txd = e_txd;
        return v;
    endfunction

    // Expected outcome of one command from the framing rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t m;
        int   need;
        m = v;
        need = v.b0[7] ? 2 : 3;
        m.e_err = 0; m.e_strobe = 0; m.e_rnw = 0; m.e_core = 0;
        m.e_reg = 0; m.e_data = 0; m.e_tx = 0; m.e_txd = 0;
        if (v.b0[6:4] != 3'b000)
            m.e_err = 1;
        else if ((v.nb > 1 && v.gap >= TO) || (v.nb < need && v.tail >= TO))
            m.e_err = 1;
        else if (v.nb >= need) begin
            m.e_strobe = 1;
            m.e_rnw    = v.b0[7];
            m.e_core   = v.b0[3:0];
            m.e_reg    = v.b1;
            m.e_data   = v.b0[7] ? 8'h00 : v.b2;
            m.e_tx     = v.b0[7];
            m.e_txd    = v.rdata;
        end
        return m;
    endfunction

    task automatic push(input logic [7:0] b);
        bit ok;
        ok = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (rx_ready) begin
                ok = 1;
                break;
            end
            @(negedge hba_clk);
        end
        chk("push_accepted", ok, 1'b1);
        if (ok) @(negedge hba_clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_flags"}, {rx_ready, tx_valid, app_en_strobe, cmd_err, busy, app_rnw}, 6'b100000);
        chk({tag, "_fields"}, {app_core_addr, app_reg_addr, app_data_in, tx_data}, 32'h0);
    endtask

    task automatic apply(input vec_t v);
        int s0, e0, t0;
        bit ok;
        s0 = strobe_cnt; e0 = err_cnt; t0 = tx_cnt;
        mst_rdata = v.rdata;
        for (int i = 0; i < v.nb; i++) begin
            if (i > 0) repeat (v.gap) @(negedge hba_clk);
            push(i == 0 ? v.b0 : (i == 1 ? v.b1 : v.b2));
        end
        if (v.e_strobe) chk("strobe_after_last_byte", app_en_strobe, 1'b1);
        repeat (v.tail) @(negedge hba_clk);
        if (v.e_strobe) begin
            ok = 0;
            for (int k = 0; k < 300; k++) begin
                if (strobe_cnt > s0) begin ok = 1; break; end
                @(negedge hba_clk);
            end
            chk("strobe_seen", ok, 1'b1);
            chk("app_core_addr", last_core, v.e_core);
            chk("app_reg_addr", last_reg, v.e_reg);
            chk("app_data_in", last_data, v.e_data);
            chk("app_rnw", last_rnw, v.e_rnw);
            if (v.e_tx) begin
                ok = 0;
                for (int k = 0; k < 300; k++) begin
                    if (tx_valid) begin ok = 1; break; end
                    @(negedge hba_clk);
                end
                chk("tx_valid_seen", ok, 1'b1);
                chk("tx_data", tx_data, v.e_txd);
                for (int k = 0; k < v.stall; k++) begin
                    @(negedge hba_clk);
                    chk("tx_valid_held", {tx_valid, tx_data}, {1'b1, v.e_txd});
                end
                tx_ready = 1'b1;
                @(negedge hba_clk);
                tx_ready = 1'b0;
                chk("tx_valid_cleared", tx_valid, 1'b0);
            end
            ok = 0;
            for (int k = 0; k < 300; k++) begin
                if (!busy) begin ok = 1; break; end
                @(negedge hba_clk);
            end
            chk("completed", ok, 1'b1);
        end
        repeat (2) @(negedge hba_clk);
        chk("strobe_count", strobe_cnt - s0, v.e_strobe);
        chk("cmd_err_count", err_cnt - e0, v.e_err);
        chk("tx_byte_count", tx_cnt - t0, v.e_tx);
        chk("idle_after_cmd", {busy, tx_valid, rx_ready}, 3'b001);
    endtask

    vec_t vecs[10];

    initial begin
        int s0, e0, t0;
        bit ok;
        hba_reset = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b0;
        repeat (3) @(negedge hba_clk);
        check_reset_vals("reset_start");
        hba_reset = 1'b0;
        @(negedge hba_clk);
        chk("after_reset_idle", {busy, rx_ready}, 2'b01);

        //            b0     b1     b2     nb gap tail stall rdata  err str rnw core reg    data   tx txd
        vecs[0] = mk(8'h03, 8'h10, 8'hA5, 3, 0,  0,  0, 8'h00, 0, 1, 0, 4'h3, 8'h10, 8'hA5, 0, 8'h00);
        vecs[1] = mk(8'h82, 8'h04, 8'h00, 2, 0,  0,  5, 8'h5C, 0, 1, 1, 4'h2, 8'h04, 8'h00, 1, 8'h5C);
        vecs[2] = mk(8'h13, 8'h00, 8'h00, 1, 0,  2,  0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 8'h00, 0, 8'h00);
        vecs[3] = mk(8'h01, 8'h00, 8'hFF, 3, 0,  0,  0, 8'h00, 0, 1, 0, 4'h1, 8'h00, 8'hFF, 0, 8'h00);
        vecs[4] = mk(8'h01, 8'h00, 8'h00, 1, 0, 10,  0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 8'h00, 0, 8'h00);
        vecs[5] = mk(8'h81, 8'h02, 8'h00, 2, 0,  0,  0, 8'h3E, 0, 1, 1, 4'h1, 8'h02, 8'h00, 1, 8'h3E);
        vecs[6] = mk(8'h0F, 8'hAA, 8'h55, 3, 7,  0,  0, 8'h00, 0, 1, 0, 4'hF, 8'hAA, 8'h55, 0, 8'h00);
        vecs[7] = mk(8'h05, 8'h20, 8'h00, 2, 0,  9,  0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 8'h00, 0, 8'h00);
        vecs[8] = mk(8'hF0, 8'h00, 8'h00, 1, 0,  2,  0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 8'h00, 0, 8'h00);
        vecs[9] = mk(8'h8A, 8'hFF, 8'h00, 2, 0,  0,  2, 8'hA5, 0, 1, 1, 4'hA, 8'hFF, 8'h00, 1, 8'hA5);
        for (int i = 0; i < 10; i++) apply(vecs[i]);

        // Reset while waiting for the master; its late completion must be ignored.
        mst_en = 1'b0;
        s0 = strobe_cnt; t0 = tx_cnt; e0 = err_cnt;
        push(8'h03); push(8'h10); push(8'hA5);
        repeat (3) @(negedge hba_clk);
        chk("wait_busy", {busy, rx_ready}, 2'b10);
        hba_reset = 1'b1;
        #1;
        check_reset_vals("reset_mid_wait");
        @(negedge hba_clk);
        hba_reset = 1'b0;
        @(negedge hba_clk);
        man_valid = 1'b1;
        @(negedge hba_clk);
        man_valid = 1'b0;
        repeat (3) @(negedge hba_clk);
        chk("late_valid_ignored", {busy, tx_valid, rx_ready}, 3'b001);
        chk("reset_wait_counts", {strobe_cnt - s0, tx_cnt - t0, err_cnt - e0}, {32'd1, 32'd0, 32'd0});
        mst_en = 1'b1;

        // Two writes with rx_valid never dropped.
        mst_delay = 3;
        s0 = strobe_cnt; e0 = err_cnt;
        push(8'h03); push(8'h11); push(8'h22);
        push(8'h04); push(8'h33); push(8'h44);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (!busy) begin ok = 1; break; end
            @(negedge hba_clk);
        end
        chk("b2b_completed", ok, 1'b1);
        repeat (2) @(negedge hba_clk);
        chk("b2b_strobes", strobe_cnt - s0, 2);
        chk("b2b_second", {last_rnw, last_core, last_reg, last_data}, {1'b0, 4'h4, 8'h33, 8'h44});
        chk("b2b_no_err", err_cnt - e0, 0);

        // Random commands against the model.
        for (int it = 0; it < 150; it++) begin
            vec_t v;
            int   kind;
            logic rnw;
            kind = $urandom_range(0, 9);
            rnw  = 1'($urandom_range(0, 1));
            v = '0;
            v.b0 = {rnw, 3'b000, 4'($urandom)};
            v.b1 = 8'($urandom);
            v.b2 = 8'($urandom);
            v.rdata = 8'($urandom);
            v.stall = $urandom_range(0, 3);
            v.gap = $urandom_range(0, TO - 1);
            v.tail = 0;
            v.nb = rnw ? 2 : 3;
            if (kind < 2) begin
                v.b0[6:4] = 3'($urandom_range(1, 7));
                v.nb = 1;
                v.tail = 2;
            end else if (kind < 4) begin
                v.nb = rnw ? 1 : $urandom_range(1, 2);
                v.tail = TO + $urandom_range(0, 3);
            end
            mst_delay = $urandom_range(1, 4);
            apply(model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hba_uart_cmd.md
HBA_UART_CMD -- requirements
Module: hba_uart_cmd

Interface
REQ-001 SHALL have parameter PERIPH_ADDR_WIDTH, default 4, width of the core-address field.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 8, width of the register-address field.
REQ-003 SHALL have parameter RX_TIMEOUT, default 50000, idle clocks after which a partial command is discarded.
REQ-004 SHALL have port hba_clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port hba_reset  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port rx_data  in  8  received command byte.
REQ-007 SHALL have port rx_valid  in  1  rx_data valid; a byte transfers when rx_valid and rx_ready are both 1.
REQ-008 SHALL have port rx_ready  out  1  block accepts a byte this cycle.
REQ-009 SHALL have port tx_data  out  8  read-response byte.
REQ-010 SHALL have port tx_valid  out  1  tx_data valid; held until tx_ready.
REQ-011 SHALL have port tx_ready  in  1  downstream consumes tx_data when 1 with tx_valid.
REQ-012 SHALL have ports app_core_addr  out  PERIPH_ADDR_WIDTH,  app_reg_addr  out  REG_ADDR_WIDTH,  app_data_in  out  8,  app_rnw  out  1: transfer request fields to the bus master.
REQ-013 SHALL have port app_en_strobe  out  1  one-cycle start pulse to the bus master.
REQ-014 SHALL have ports app_data_out  in  8  and  app_valid_out  in  1: master completion data and one-cycle done pulse.
REQ-015 SHALL have ports busy  out  1 (state not CMD) and cmd_err  out  1 (one-cycle error pulse).

Function
REQ-016 SHALL parse byte 0 as {rnw, 3'b000, core_addr[3:0]}, byte 1 as reg_addr, byte 2 (writes only) as write data.
REQ-017 SHALL implement states CMD, REG, DATA, ISSUE, WAIT, TX; rx_ready = 1 only in CMD, REG, DATA.
REQ-018 SHALL, in CMD, on a byte with bits[6:4] nonzero, discard it, pulse cmd_err, stay in CMD.
REQ-019 SHALL, in CMD, on a valid byte, latch rnw and core_addr and go to REG.
REQ-020 SHALL, in REG, latch reg_addr, then go to ISSUE if rnw=1, else DATA.
REQ-021 SHALL, in DATA, latch the write byte and go to ISSUE.
REQ-022 SHALL, in ISSUE, assert app_en_strobe for exactly one cycle, the cycle after the last command byte is accepted, then go to WAIT.
REQ-023 SHALL hold app_core_addr, app_reg_addr, app_data_in, app_rnw stable from ISSUE until leaving WAIT; app_data_in = 0 for reads.
REQ-024 SHALL, in WAIT, on app_valid_out: write -> CMD; read -> register tx_data = app_data_out, tx_valid = 1, go to TX.
REQ-025 SHALL, in TX, drop tx_valid and return to CMD on the cycle tx_valid and tx_ready are both 1.
REQ-026 SHALL ignore app_valid_out outside WAIT.
REQ-027 SHALL, in REG or DATA, count idle cycles (reset on each accepted byte); on reaching RX_TIMEOUT, discard the partial command, pulse cmd_err, go to CMD.
REQ-028 SHALL have no timeout in WAIT or TX; the block waits indefinitely.
REQ-029 SHALL saturate the idle counter, never wrapping.

Reset
REQ-030 SHALL, on hba_reset asserted at any time including mid-command, immediately set state CMD; rx_ready = 1; tx_valid, app_en_strobe, cmd_err, busy = 0; all address/data outputs and counter = 0.
REQ-031 SHALL resume in CMD on the first clock edge after reset deasserts.

Verification
REQ-032 Write: bytes 0x03, 0x10, 0xA5 -> one app_en_strobe pulse with core 3, reg 0x10, data 0xA5, rnw 0; app_valid_out -> busy 0, no tx byte.
REQ-033 Read: bytes 0x82, 0x04; master returns 0x5C -> tx_data 0x5C, tx_valid held through 5 cycles of tx_ready=0, cleared on the handshake.
REQ-034 Bad command: byte 0x13 -> cmd_err one pulse, no strobe; following 0x01, 0x00, 0xFF -> normal write.
REQ-035 Timeout (RX_TIMEOUT=8): byte 0x01 then 8 idle cycles -> cmd_err pulse, state CMD; next 0x81, 0x02 -> read of core 1, reg 2.
REQ-036 Reset mid-WAIT: hba_reset during WAIT -> outputs at reset values; late app_valid_out ignored; no tx byte.
REQ-037 Back-to-back: two writes with rx_valid held high -> exactly two strobes, rx_ready 0 from ISSUE until completion.
